// File: rtl/microsequencer_stack.sv
// Next-microaddress sequencer: condition select, incrementer, return stack and
// hardware loop counter feeding the microstore address.
module microsequencer_stack #(
   parameter int unsigned AW         = 7,
   parameter int unsigned NCOND      = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CW         = 8,
   parameter int unsigned RESET_ADDR = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [2:0]                   seq_op,
   input  logic [$clog2(NCOND)-1:0]     cond_sel,
   input  logic                         inv,
   input  logic [NCOND-1:0]             cond_in,
   input  logic [AW-1:0]                target,
   input  logic [CW-1:0]                cnt_in,
   input  logic [AW-1:0]                decode_addr,
   output logic [AW-1:0]                next_addr,
   output logic [AW-1:0]                uaddr,
   output logic [$clog2(DEPTH+1)-1:0]   sp,
   output logic [CW-1:0]                loop_cnt,
   output logic                         stk_ovf,
   output logic                         stk_unf
);

   localparam int unsigned CSW = $clog2(NCOND);
   localparam int unsigned SPW = $clog2(DEPTH+1);

   typedef enum logic [2:0] {
      OP_CONT     = 3'd0,
      OP_JMP      = 3'd1,
      OP_CJMP     = 3'd2,
      OP_DISPATCH = 3'd3,
      OP_CALL     = 3'd4,
      OP_RET      = 3'd5,
      OP_LDCNT    = 3'd6,
      OP_LOOP     = 3'd7
   } seq_op_t;

   seq_op_t         op;
   logic [AW-1:0]   stack [DEPTH];
   logic [AW-1:0]   inc;
   logic [AW-1:0]   top;
   logic            sel_bit;
   logic            c;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            set_ovf;
   logic            set_unf;
   logic            ld_cnt;
   logic            dec_cnt;

   assign op    = seq_op_t'(seq_op);
   assign inc   = uaddr + AW'(1);
   assign full  = (sp == SPW'(DEPTH));
   assign empty = (sp == '0);

   // Selector values at or beyond NCOND match no input and leave the bit at 0.
   always_comb begin
      sel_bit = 1'b0;
      for (int unsigned i = 0; i < NCOND; i++)
         if (cond_sel == CSW'(i)) sel_bit = cond_in[i];
   end

   assign c = sel_bit ^ inv;

   always_comb begin
      top = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         if (sp == SPW'(i + 1)) top = stack[i];
   end

   always_comb begin
      next_addr = inc;
      push      = 1'b0;
      pop       = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      ld_cnt    = 1'b0;
      dec_cnt   = 1'b0;
      unique case (op)
         OP_CONT:     next_addr = inc;
         OP_JMP:      next_addr = target;
         OP_CJMP:     next_addr = c ? target : inc;
         OP_DISPATCH: next_addr = decode_addr;
         OP_CALL: begin
            if (c && !full) begin
               push      = 1'b1;
               next_addr = target;
            end else if (c) begin
               set_ovf = 1'b1;
            end
         end
         OP_RET: begin
            if (!empty) begin
               pop       = 1'b1;
               next_addr = top;
            end else begin
               set_unf = 1'b1;
            end
         end
         OP_LDCNT:    ld_cnt = 1'b1;
         OP_LOOP: begin
            if (loop_cnt != '0) begin
               dec_cnt   = 1'b1;
               next_addr = target;
            end
         end
         default:     next_addr = inc;
      endcase
      if (reset) next_addr = AW'(RESET_ADDR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uaddr    <= AW'(RESET_ADDR);
         sp       <= '0;
         loop_cnt <= '0;
         stk_ovf  <= 1'b0;
         stk_unf  <= 1'b0;
      end else begin
         uaddr <= next_addr;
         if (push)
            sp <= sp + SPW'(1);
         else if (pop)
            sp <= sp - SPW'(1);
         if (ld_cnt)
            loop_cnt <= cnt_in;
         else if (dec_cnt)
            loop_cnt <= loop_cnt - CW'(1);
         if (set_ovf) stk_ovf <= 1'b1;
         if (set_unf) stk_unf <= 1'b1;
      end
   end

   // Stack storage needs no reset: only entries below sp are ever read.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++)
         if (push && sp == SPW'(i)) stack[i] <= inc;
   end

endmodule

// File: tb/tb_microsequencer_stack.sv
// Directed bench for microsequencer_stack (NCOND=3 so an out-of-range select exists).
module tb_microsequencer_stack;

   localparam int unsigned AW = 7;
   localparam int unsigned NCOND = 3;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    seq_op;
   logic [1:0]    cond_sel;
   logic          inv;
   logic [2:0]    cond_in;
   logic [AW-1:0] target;
   logic [CW-1:0] cnt_in;
   logic [AW-1:0] decode_addr;
   logic [AW-1:0] next_addr;
   logic [AW-1:0] uaddr;
   logic [2:0]    sp;
   logic [CW-1:0] loop_cnt;
   logic          stk_ovf;
   logic          stk_unf;

   int total = 0;
   int bad = 0;
   int body_visits;

   microsequencer_stack #(.AW(AW), .NCOND(NCOND), .DEPTH(DEPTH), .CW(CW), .RESET_ADDR(0)) dut (
      .clk(clk), .reset(reset), .seq_op(seq_op), .cond_sel(cond_sel), .inv(inv),
      .cond_in(cond_in), .target(target), .cnt_in(cnt_in), .decode_addr(decode_addr),
      .next_addr(next_addr), .uaddr(uaddr), .sp(sp), .loop_cnt(loop_cnt),
      .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [2:0] o, input logic [AW-1:0] t);
      seq_op = o;
      target = t;
      step();
   endtask

   initial begin
      reset = 1'b1; seq_op = 3'd0; cond_sel = 2'd1; inv = 1'b0; cond_in = 3'b010;
      target = '0; cnt_in = '0; decode_addr = '0;
      repeat (2) step();
      chk("rst_uaddr", uaddr, 0);
      chk("rst_sp", sp, 0);
      chk("rst_cnt", loop_cnt, 0);
      chk("rst_ovf", stk_ovf, 0);
      chk("rst_unf", stk_unf, 0);
      chk("rst_next", next_addr, 0);
      reset = 1'b0;
      #1 chk("next_after_rst", next_addr, 1);
      for (int i = 1; i <= 3; i++) begin
         op(3'd0, '0);
         chk("cont_seq", uaddr, i);
      end
      chk("next_comb", next_addr, 4);

      op(3'd1, 7'd127); chk("jmp127", uaddr, 127);
      op(3'd0, '0);     chk("wrap", uaddr, 0);

      // conditional jumps from 5
      op(3'd1, 7'd5); inv = 1'b0; cond_sel = 2'd1;
      op(3'd2, 7'd40); chk("cjmp_taken", uaddr, 40);
      op(3'd1, 7'd5); inv = 1'b1;
      op(3'd2, 7'd40); chk("cjmp_inv", uaddr, 6);
      op(3'd1, 7'd5); cond_sel = 2'd3; inv = 1'b1;
      op(3'd2, 7'd40); chk("cjmp_oor_inv", uaddr, 40);
      op(3'd1, 7'd5); inv = 1'b0;
      op(3'd2, 7'd40); chk("cjmp_oor", uaddr, 6);
      op(3'd1, 7'd5); cond_sel = 2'd0;
      op(3'd2, 7'd40); chk("cjmp_sel0", uaddr, 6);

      // call / return
      cond_sel = 2'd1; inv = 1'b0;
      op(3'd1, 7'd10);
      op(3'd4, 7'd60); chk("call_addr", uaddr, 60); chk("call_sp", sp, 1);
      op(3'd5, '0);    chk("ret_addr", uaddr, 11); chk("ret_sp", sp, 0);
      inv = 1'b1;
      op(3'd4, 7'd60); chk("call_nc_addr", uaddr, 12); chk("call_nc_sp", sp, 0);
      inv = 1'b0;
      op(3'd4, 7'd60); op(3'd4, 7'd70); op(3'd4, 7'd80); op(3'd4, 7'd90);
      chk("nest_addr", uaddr, 90); chk("nest_sp", sp, 4); chk("nest_ovf", stk_ovf, 0);
      op(3'd4, 7'd100);
      chk("ovf_addr", uaddr, 91); chk("ovf_sp", sp, 4); chk("ovf_flag", stk_ovf, 1);
      op(3'd5, '0); chk("pop1", uaddr, 81);
      op(3'd5, '0); chk("pop2", uaddr, 71);
      op(3'd5, '0); chk("pop3", uaddr, 61);
      op(3'd5, '0); chk("pop4", uaddr, 13); chk("pop_sp", sp, 0);
      chk("ovf_sticky", stk_ovf, 1); chk("unf_clear", stk_unf, 0);

      // underflow
      op(3'd1, 7'd20);
      op(3'd5, '0); chk("unf_addr", uaddr, 21); chk("unf_flag", stk_unf, 1); chk("unf_sp", sp, 0);
      repeat (10) op(3'd0, '0);
      chk("unf_sticky", stk_unf, 1); chk("unf_cont_addr", uaddr, 31);

      // hardware loop: body at 30, LOOP at 31
      op(3'd1, 7'd29);
      cnt_in = 8'd3;
      op(3'd6, '0); chk("ldcnt_addr", uaddr, 30); chk("ldcnt_val", loop_cnt, 3);
      body_visits = 1;
      for (int k = 0; k < 4; k++) begin
         op(3'd0, '0);
         chk("loop_cnt_seq", loop_cnt, 3 - k);
         op(3'd7, 7'd30);
         if (uaddr == 7'd30) body_visits++;
         chk("loop_addr", uaddr, (k < 3) ? 30 : 32);
      end
      chk("loop_body", body_visits, 4);
      chk("loop_end_cnt", loop_cnt, 0);
      op(3'd7, 7'd30); chk("loop_zero_fall", uaddr, 33); chk("loop_no_unf", loop_cnt, 0);

      decode_addr = 7'd77;
      op(3'd3, '0); chk("dispatch", uaddr, 77);

      // asynchronous reset mid-sequence
      cnt_in = 8'd5;
      op(3'd6, '0);
      op(3'd4, 7'd60); op(3'd4, 7'd70);
      chk("pre_rst_sp", sp, 2); chk("pre_rst_cnt", loop_cnt, 5); chk("pre_rst_addr", uaddr, 70);
      seq_op = 3'd0;
      #2 reset = 1'b1;
      #1;
      chk("arst_uaddr", uaddr, 0);
      chk("arst_sp", sp, 0);
      chk("arst_cnt", loop_cnt, 0);
      chk("arst_ovf", stk_ovf, 0);
      chk("arst_unf", stk_unf, 0);
      chk("arst_next", next_addr, 0);
      step();
      reset = 1'b0;
      op(3'd0, '0); chk("post_rst", uaddr, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
